// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, owner encoding,
// and the wait-state counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding core and memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            ls_req;
  logic            ls_we;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_be;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [DW-1:0]   ls_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: chooses between fetch and load/store requests.
// ARB_RR_EN selects round-robin on contention; otherwise load/store has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       ls_req,
  input  owner_e     last_owner,
  output logic [1:0] gnt_oh,
  output owner_e     winner
);

`ifndef ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    winner = OWN_LS;
    if (if_req && ls_req) begin
`ifdef ARB_RR_EN
      winner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
`else
      winner = OWN_LS;
`endif
    end else if (if_req) begin
      winner = OWN_IF;
    end
    gnt_oh = 2'b00;
    if (if_req || ls_req) gnt_oh = (winner == OWN_LS) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences IF and LS accesses onto one memory port (grant, strobe, wait, response).
// Define ARB_RR_EN for round-robin arbitration instead of fixed load/store priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  localparam int BW = DW / 8;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT_CYCLES must be within 1..15");
  end
  if (DW % 8 != 0) begin : g_bad_dw
    $error("mem_port_arbiter: DW must be a multiple of 8");
  end

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_owner_q, last_owner_d;
  owner_e                winner;
  logic [1:0]            gnt_oh;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [BW-1:0]         be_q, be_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]         if_rdata_q, if_rdata_d;
  logic [DW-1:0]         ls_rdata_q, ls_rdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic                  ls_zero_q, ls_zero_d;
  logic                  mem_en_q, mem_en_d;
  logic                  busy_q, busy_d;
  logic                  idle;

  assign idle = (state_q == IDLE);

  arb_pick u_pick (
    .if_req     (bus.if_req),
    .ls_req     (bus.ls_req),
    .last_owner (last_owner_q),
    .gnt_oh     (gnt_oh),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_oh != 2'b00) begin
          owner_d      = winner;
          last_owner_d = winner;
          if (winner == OWN_LS) begin
            we_d    = bus.ls_we;
            addr_d  = bus.ls_addr;
            wdata_d = bus.ls_wdata;
            be_d    = bus.ls_be;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            be_d    = '1;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_LS) ls_rdata_d = bus.mem_rdata;
          else                   if_rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they leave the flops glitch-free.
    mem_en_d    = (state_d == ACCESS);
    busy_d      = (state_d != IDLE);
    if_rvalid_d = (state_d == RESP) && (owner_d == OWN_IF);
    ls_rvalid_d = (state_d == RESP) && (owner_d == OWN_LS);
    ls_zero_d   = ls_rvalid_d && we_d;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      ls_zero_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      if_rvalid_q  <= if_rvalid_d;
      ls_rvalid_q  <= ls_rvalid_d;
      ls_zero_q    <= ls_zero_d;
      mem_en_q     <= mem_en_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.if_gnt    = idle & gnt_oh[0];
  assign bus.ls_gnt    = idle & gnt_oh[1];
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_zero_q ? '0 : ls_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign busy          = busy_q;

endmodule
